// File: rtl/decode_stage_if.sv
// ID-stage bundle: IF/ID inputs, WB write port, stall output and the ID/EX register outputs.
// master drives the ID/WB side and observes EX; slave is the decode stage itself.
interface decode_stage_if #(
    parameter int XLEN = 32
) ();
    logic [XLEN-1:0] PC_ID;
    logic [31:0]     INSTRUCTION_ID;
    logic            VALID_ID;
    logic            FLUSH_ID;
    logic            RegWrite_WB;
    logic [4:0]      RD_WB;
    logic [XLEN-1:0] ALU_DATA_WB;

    logic            STALL_ID;
    logic            VALID_EX;
    logic            RegWrite_EX;
    logic            MemtoReg_EX;
    logic            MemRead_EX;
    logic            MemWrite_EX;
    logic            ALUSrc_EX;
    logic            Branch_EX;
    logic [1:0]      ALUop_EX;
    logic [XLEN-1:0] PC_EX;
    logic [XLEN-1:0] IMM_EX;
    logic [XLEN-1:0] REG_DATA1_EX;
    logic [XLEN-1:0] REG_DATA2_EX;
    logic [4:0]      RS1_EX;
    logic [4:0]      RS2_EX;
    logic [4:0]      RD_EX;
    logic [2:0]      FUNCT3_EX;
    logic [6:0]      FUNCT7_EX;

    modport master (
        output PC_ID, INSTRUCTION_ID, VALID_ID, FLUSH_ID, RegWrite_WB, RD_WB, ALU_DATA_WB,
        input  STALL_ID, VALID_EX, RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX,
               ALUSrc_EX, Branch_EX, ALUop_EX, PC_EX, IMM_EX, REG_DATA1_EX, REG_DATA2_EX,
               RS1_EX, RS2_EX, RD_EX, FUNCT3_EX, FUNCT7_EX
    );

    modport slave (
        input  PC_ID, INSTRUCTION_ID, VALID_ID, FLUSH_ID, RegWrite_WB, RD_WB, ALU_DATA_WB,
        output STALL_ID, VALID_EX, RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX,
               ALUSrc_EX, Branch_EX, ALUop_EX, PC_EX, IMM_EX, REG_DATA1_EX, REG_DATA2_EX,
               RS1_EX, RS2_EX, RD_EX, FUNCT3_EX, FUNCT7_EX
    );
endinterface

// File: rtl/decode_stage.sv
// Decode stage: opcode decode, bypassed register file, load-use stall detection and
// the ID/EX pipeline register with bubble insertion on stall or flush.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    decode_stage_if.slave bus
);
    localparam int RA = $clog2(NREGS);

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    logic [XLEN-1:0] regs [NREGS];
    logic [6:0]      opcode;
    logic [RA-1:0]   rs1, rs2, rd, wb_addr;
    logic            wb_en;
    logic            uses_rs1, uses_rs2;
    ctrl_t           ctrl_dec, ctrl_id, ctrl_ex;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rdata1, rdata2;
    logic            valid_ex;
    logic [4:0]      rd_ex;
    logic            haz;
    logic            stall;
    logic            unused_bits;

    assign opcode  = bus.INSTRUCTION_ID[6:0];
    assign rd      = bus.INSTRUCTION_ID[7 +: RA];
    assign rs1     = bus.INSTRUCTION_ID[15 +: RA];
    assign rs2     = bus.INSTRUCTION_ID[20 +: RA];
    assign wb_addr = bus.RD_WB[RA-1:0];
    assign wb_en   = bus.RegWrite_WB && (wb_addr != '0);

    // Upper address bits are dropped when NREGS < 32.
    assign unused_bits = ^{bus.RD_WB, bus.INSTRUCTION_ID};

    always_comb begin
        ctrl_dec = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        imm      = '0;
        case (opcode)
            7'b0110011: begin
                ctrl_dec.reg_write = 1'b1;
                ctrl_dec.alu_op    = 2'b10;
                uses_rs1           = 1'b1;
                uses_rs2           = 1'b1;
            end
            7'b0010011: begin
                ctrl_dec.reg_write = 1'b1;
                ctrl_dec.alu_src   = 1'b1;
                ctrl_dec.alu_op    = 2'b10;
                uses_rs1           = 1'b1;
                imm = {{(XLEN-12){bus.INSTRUCTION_ID[31]}}, bus.INSTRUCTION_ID[31:20]};
            end
            7'b0000011: begin
                ctrl_dec.reg_write  = 1'b1;
                ctrl_dec.mem_read   = 1'b1;
                ctrl_dec.mem_to_reg = 1'b1;
                ctrl_dec.alu_src    = 1'b1;
                uses_rs1            = 1'b1;
                imm = {{(XLEN-12){bus.INSTRUCTION_ID[31]}}, bus.INSTRUCTION_ID[31:20]};
            end
            7'b0100011: begin
                ctrl_dec.mem_write = 1'b1;
                ctrl_dec.alu_src   = 1'b1;
                uses_rs1           = 1'b1;
                uses_rs2           = 1'b1;
                imm = {{(XLEN-12){bus.INSTRUCTION_ID[31]}}, bus.INSTRUCTION_ID[31:25],
                       bus.INSTRUCTION_ID[11:7]};
            end
            7'b1100011: begin
                ctrl_dec.branch = 1'b1;
                ctrl_dec.alu_op = 2'b01;
                uses_rs1        = 1'b1;
                uses_rs2        = 1'b1;
                imm = {{(XLEN-13){bus.INSTRUCTION_ID[31]}}, bus.INSTRUCTION_ID[31],
                       bus.INSTRUCTION_ID[7], bus.INSTRUCTION_ID[30:25],
                       bus.INSTRUCTION_ID[11:8], 1'b0};
            end
            default: begin
                ctrl_dec = '0;
            end
        endcase
    end

    assign ctrl_id = bus.VALID_ID ? ctrl_dec : '0;

    // Same-cycle write-back is forwarded so ID never sees a stale value.
    assign rdata1 = (rs1 == '0) ? '0 :
                    (wb_en && wb_addr == rs1) ? bus.ALU_DATA_WB : regs[rs1];
    assign rdata2 = (rs2 == '0) ? '0 :
                    (wb_en && wb_addr == rs2) ? bus.ALU_DATA_WB : regs[rs2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[wb_addr] <= bus.ALU_DATA_WB;
        end
    end

    assign haz = valid_ex && ctrl_ex.mem_read && (rd_ex != 5'd0) && bus.VALID_ID &&
                 ((uses_rs1 && rd_ex == 5'(rs1)) || (uses_rs2 && rd_ex == 5'(rs2)));
    assign stall = haz && !bus.FLUSH_ID;
    assign bus.STALL_ID = stall;

    // Bubbles clear only valid and control; the datapath fields are don't-care then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_ex         <= 1'b0;
            ctrl_ex          <= '0;
            rd_ex            <= '0;
            bus.PC_EX        <= '0;
            bus.IMM_EX       <= '0;
            bus.REG_DATA1_EX <= '0;
            bus.REG_DATA2_EX <= '0;
            bus.RS1_EX       <= '0;
            bus.RS2_EX       <= '0;
            bus.FUNCT3_EX    <= '0;
            bus.FUNCT7_EX    <= '0;
        end else if (bus.FLUSH_ID || stall) begin
            valid_ex <= 1'b0;
            ctrl_ex  <= '0;
        end else begin
            valid_ex         <= bus.VALID_ID;
            ctrl_ex          <= ctrl_id;
            rd_ex            <= 5'(rd);
            bus.PC_EX        <= bus.PC_ID;
            bus.IMM_EX       <= imm;
            bus.REG_DATA1_EX <= rdata1;
            bus.REG_DATA2_EX <= rdata2;
            bus.RS1_EX       <= 5'(rs1);
            bus.RS2_EX       <= 5'(rs2);
            bus.FUNCT3_EX    <= bus.INSTRUCTION_ID[14:12];
            bus.FUNCT7_EX    <= bus.INSTRUCTION_ID[31:25];
        end
    end

    assign bus.VALID_EX    = valid_ex;
    assign bus.RD_EX       = rd_ex;
    assign bus.RegWrite_EX = ctrl_ex.reg_write;
    assign bus.MemtoReg_EX = ctrl_ex.mem_to_reg;
    assign bus.MemRead_EX  = ctrl_ex.mem_read;
    assign bus.MemWrite_EX = ctrl_ex.mem_write;
    assign bus.ALUSrc_EX   = ctrl_ex.alu_src;
    assign bus.Branch_EX   = ctrl_ex.branch;
    assign bus.ALUop_EX    = ctrl_ex.alu_op;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one 32-bit/32-register instance and one 64-bit/16-register
// instance, with hand-computed instruction encodings and expected ID/EX contents.
module tb_decode_stage;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    decode_stage_if #(.XLEN(32)) ia ();
    decode_stage_if #(.XLEN(64)) ib ();

    decode_stage #(.XLEN(32), .NREGS(32)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
    decode_stage #(.XLEN(64), .NREGS(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [31:0] instr,
                          input logic valid, input logic flush);
        ia.PC_ID          = pc;
        ia.INSTRUCTION_ID = instr;
        ia.VALID_ID       = valid;
        ia.FLUSH_ID       = flush;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
        ia.RegWrite_WB = en;
        ia.RD_WB       = rd;
        ia.ALU_DATA_WB = data;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        set_wb(1'b0, 5'd0, 32'h0);
        ib.PC_ID = '0; ib.INSTRUCTION_ID = '0; ib.VALID_ID = 1'b0; ib.FLUSH_ID = 1'b0;
        ib.RegWrite_WB = 1'b0; ib.RD_WB = '0; ib.ALU_DATA_WB = '0;

        // Reset held with add x3,x1,x2 in ID
        set_id(32'h100, 32'h002081B3, 1'b1, 1'b0);
        tick();
        check("rst_valid", ia.VALID_EX, 0);
        check("rst_regwrite", ia.RegWrite_EX, 0);
        check("rst_aluop", ia.ALUop_EX, 0);
        check("rst_pc", ia.PC_EX, 0);
        check("rst_rd", ia.RD_EX, 0);
        check("rst_data1", ia.REG_DATA1_EX, 0);
        check("rst_stall", ia.STALL_ID, 0);
        check("rst_b_valid", ib.VALID_EX, 0);

        // Release: first edge loads the add
        rst_n = 1'b1;
        tick();
        check("add_valid", ia.VALID_EX, 1);
        check("add_regwrite", ia.RegWrite_EX, 1);
        check("add_aluop", ia.ALUop_EX, 2'b10);
        check("add_rd", ia.RD_EX, 3);
        check("add_rs1", ia.RS1_EX, 1);
        check("add_rs2", ia.RS2_EX, 2);
        check("add_pc", ia.PC_EX, 32'h100);
        check("add_alusrc", ia.ALUSrc_EX, 0);

        // addi x1,x0,-5
        set_id(32'h104, 32'hFFB00093, 1'b1, 1'b0);
        tick();
        check("addi_imm", ia.IMM_EX, 32'hFFFFFFFB);
        check("addi_alusrc", ia.ALUSrc_EX, 1);
        check("addi_regwrite", ia.RegWrite_EX, 1);
        check("addi_aluop", ia.ALUop_EX, 2'b10);

        // sw x2,-4(x3)
        set_id(32'h108, 32'hFE21AE23, 1'b1, 1'b0);
        tick();
        check("sw_imm", ia.IMM_EX, 32'hFFFFFFFC);
        check("sw_memwrite", ia.MemWrite_EX, 1);
        check("sw_regwrite", ia.RegWrite_EX, 0);
        check("sw_aluop", ia.ALUop_EX, 2'b00);
        check("sw_funct3", ia.FUNCT3_EX, 3'd2);

        // beq x1,x2,+8
        set_id(32'h10C, 32'h00208463, 1'b1, 1'b0);
        tick();
        check("beq_imm", ia.IMM_EX, 32'h8);
        check("beq_branch", ia.Branch_EX, 1);
        check("beq_aluop", ia.ALUop_EX, 2'b01);
        check("beq_alusrc", ia.ALUSrc_EX, 0);

        // WB writes x5 while add x6,x5,x0 reads it
        set_wb(1'b1, 5'd5, 32'h1234);
        set_id(32'h110, 32'h00028333, 1'b1, 1'b0);
        tick();
        check("byp_data1", ia.REG_DATA1_EX, 32'h1234);
        check("byp_data2", ia.REG_DATA2_EX, 0);

        // WB writes x0 while the same add reads x5 (stored) and x0
        set_wb(1'b1, 5'd0, 32'hFFFF);
        tick();
        check("x5_stored", ia.REG_DATA1_EX, 32'h1234);
        check("x0_byp_zero", ia.REG_DATA2_EX, 0);

        // add x6,x0,x5 after the x0 write
        set_wb(1'b0, 5'd0, 32'h0);
        set_id(32'h114, 32'h00500333, 1'b1, 1'b0);
        tick();
        check("x0_read", ia.REG_DATA1_EX, 0);
        check("x5_read", ia.REG_DATA2_EX, 32'h1234);

        // lw x7,0(x1) then add x8,x7,x2 -> one-cycle stall
        set_id(32'h118, 32'h0000A383, 1'b1, 1'b0);
        #1;
        check("lw_nostall", ia.STALL_ID, 0);
        tick();
        check("lw_memread", ia.MemRead_EX, 1);
        check("lw_memtoreg", ia.MemtoReg_EX, 1);
        check("lw_rd", ia.RD_EX, 7);
        set_id(32'h200, 32'h00238433, 1'b1, 1'b0);
        #1;
        check("lu_stall", ia.STALL_ID, 1);
        tick();
        check("lu_bubble_valid", ia.VALID_EX, 0);
        check("lu_bubble_memread", ia.MemRead_EX, 0);
        check("lu_bubble_regwrite", ia.RegWrite_EX, 0);
        check("lu_stall_drop", ia.STALL_ID, 0);
        tick();
        check("lu_issue_valid", ia.VALID_EX, 1);
        check("lu_issue_rd", ia.RD_EX, 8);
        check("lu_issue_pc", ia.PC_EX, 32'h200);
        check("lu_issue_rs1", ia.RS1_EX, 7);

        // lw x7 then addi x8,x9,7: imm bits alias rs2=7 but rs2 is unused
        set_id(32'h204, 32'h0000A383, 1'b1, 1'b0);
        tick();
        set_id(32'h208, 32'h00748413, 1'b1, 1'b0);
        #1;
        check("addi_nostall", ia.STALL_ID, 0);
        tick();
        check("addi_after_lw_valid", ia.VALID_EX, 1);
        check("addi_after_lw_imm", ia.IMM_EX, 32'h7);

        // lw x0 then add x8,x0,x2
        set_id(32'h20C, 32'h0000A003, 1'b1, 1'b0);
        tick();
        set_id(32'h210, 32'h00200433, 1'b1, 1'b0);
        #1;
        check("x0_nostall", ia.STALL_ID, 0);
        tick();
        check("x0_use_valid", ia.VALID_EX, 1);

        // Load-use pair with FLUSH_ID: flush wins, no stall
        set_id(32'h214, 32'h0000A383, 1'b1, 1'b0);
        tick();
        set_id(32'h218, 32'h00238433, 1'b1, 1'b1);
        #1;
        check("flush_stall", ia.STALL_ID, 0);
        tick();
        check("flush_bubble_valid", ia.VALID_EX, 0);
        check("flush_bubble_regwrite", ia.RegWrite_EX, 0);
        set_id(32'h300, 32'h00238433, 1'b1, 1'b0);
        #1;
        check("post_flush_stall", ia.STALL_ID, 0);
        tick();
        check("post_flush_valid", ia.VALID_EX, 1);

        // Invalid ID slot, then an unknown opcode (lui x1,0x12345)
        set_id(32'h304, 32'h002081B3, 1'b0, 1'b0);
        tick();
        check("inv_valid", ia.VALID_EX, 0);
        check("inv_regwrite", ia.RegWrite_EX, 0);
        set_id(32'h308, 32'h123450B7, 1'b1, 1'b0);
        tick();
        check("unk_valid", ia.VALID_EX, 1);
        check("unk_regwrite", ia.RegWrite_EX, 0);
        check("unk_imm", ia.IMM_EX, 0);

        // 64-bit / 16-register instance
        set_id(32'h30C, 32'h0, 1'b0, 1'b0);
        ib.RegWrite_WB = 1'b1;
        ib.RD_WB       = 5'd15;
        ib.ALU_DATA_WB = 64'h8000_0000_0000_0001;
        tick();
        ib.RegWrite_WB = 1'b0;
        ib.PC_ID          = 64'hFFFF_0000_0000_0040;
        ib.INSTRUCTION_ID = 32'h000780B3;
        ib.VALID_ID       = 1'b1;
        tick();
        check("b_x15_data", ib.REG_DATA1_EX, 64'h8000_0000_0000_0001);
        check("b_rs1", ib.RS1_EX, 15);
        check("b_pc", ib.PC_EX, 64'hFFFF_0000_0000_0040);
        ib.INSTRUCTION_ID = 32'hFFF00093;
        tick();
        check("b_imm_ones", ib.IMM_EX, 64'hFFFF_FFFF_FFFF_FFFF);
        check("b_alusrc", ib.ALUSrc_EX, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
